// File: rtl/rv32i_mem_pkg.sv
// State encoding and constants shared by the RV32I memory-port arbiter.
package rv32i_mem_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FCMD  = 3'd1;
    localparam logic [2:0] S_DRCMD = 3'd2;
    localparam logic [2:0] S_DWCMD = 3'd3;
    localparam logic [2:0] S_FRESP = 3'd4;
    localparam logic [2:0] S_DRESP = 3'd5;

    localparam logic [3:0] BE_WORD    = 4'hf;
    localparam logic [3:0] STARVE_MAX = 4'd15;

    typedef enum logic [2:0] {
        IDLE  = S_IDLE,
        FCMD  = S_FCMD,
        DRCMD = S_DRCMD,
        DWCMD = S_DWCMD,
        FRESP = S_FRESP,
        DRESP = S_DRESP
    } arb_state_e;

endpackage

// File: rtl/rv32i_mem_arbiter.sv
// Shares one Avalon-MM memory port between instruction fetch and the ALU load/store
// path; one access outstanding, data preferred unless fetch has waited too long.
module rv32i_mem_arbiter
    import rv32i_mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    input  logic        d_load,
    input  logic        d_store,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        stall,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_byteenable,
    output logic [31:0] mem_writedata,
    input  logic        mem_waitrequest,
    input  logic [31:0] mem_readdata,
    input  logic        mem_readdatavalid,
    output logic        err_rdv
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    arb_state_e  state_q;
    logic [3:0]  starve_q;
    logic [3:0]  starve_d;
    logic [31:0] mem_addr_q;
    logic        mem_read_q;
    logic        mem_write_q;
    logic [3:0]  mem_be_q;
    logic [31:0] mem_wdata_q;
    logic        if_gnt_q;
    logic        if_valid_q;
    logic [31:0] if_rdata_q;
    logic        d_done_q;
    logic [31:0] d_rdata_q;
    logic        err_rdv_q;

    logic data_req;
    logic arb_open;
    logic force_fetch;
    logic grant_fetch;
    logic grant_data;
    logic resp_state;

    // No grant in a completion cycle: the requester still holds its level request then.
    always_comb begin
        data_req    = d_load | d_store;
        arb_open    = (state_q == IDLE) && !d_done_q && !if_valid_q;
        force_fetch = if_req && (starve_q >= LIMIT);
        grant_fetch = arb_open && if_req && (force_fetch || !data_req);
        grant_data  = arb_open && data_req && !force_fetch;
        resp_state  = (state_q == FRESP) || (state_q == DRESP);

        starve_d = starve_q;
        if (!if_req || grant_fetch) begin
            starve_d = '0;
        end else if (grant_data && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            mem_addr_q  <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            if_gnt_q    <= 1'b0;
            if_valid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_done_q    <= 1'b0;
            d_rdata_q   <= '0;
            err_rdv_q   <= 1'b0;
        end else begin
            starve_q   <= starve_d;
            if_gnt_q   <= 1'b0;
            if_valid_q <= 1'b0;
            d_done_q   <= 1'b0;
            if (mem_readdatavalid && !resp_state) begin
                err_rdv_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (grant_data) begin
                        mem_addr_q <= d_addr;
                        if (d_store) begin
                            mem_write_q <= 1'b1;
                            mem_be_q    <= d_be;
                            mem_wdata_q <= d_wdata;
                            state_q     <= DWCMD;
                        end else begin
                            mem_read_q  <= 1'b1;
                            mem_be_q    <= BE_WORD;
                            mem_wdata_q <= '0;
                            state_q     <= DRCMD;
                        end
                    end else if (grant_fetch) begin
                        mem_addr_q  <= if_addr & ~32'h3;
                        mem_read_q  <= 1'b1;
                        mem_be_q    <= BE_WORD;
                        mem_wdata_q <= '0;
                        state_q     <= FCMD;
                    end
                end
                FCMD: begin
                    if (!mem_waitrequest) begin
                        mem_read_q <= 1'b0;
                        if_gnt_q   <= 1'b1;
                        state_q    <= FRESP;
                    end
                end
                DRCMD: begin
                    if (!mem_waitrequest) begin
                        mem_read_q <= 1'b0;
                        state_q    <= DRESP;
                    end
                end
                DWCMD: begin
                    if (!mem_waitrequest) begin
                        mem_write_q <= 1'b0;
                        d_done_q    <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                FRESP: begin
                    if (mem_readdatavalid) begin
                        if_rdata_q <= mem_readdata;
                        if_valid_q <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                DRESP: begin
                    if (mem_readdatavalid) begin
                        d_rdata_q <= mem_readdata;
                        d_done_q  <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign if_gnt         = if_gnt_q;
    assign if_valid       = if_valid_q;
    assign if_rdata       = if_rdata_q;
    assign d_done         = d_done_q;
    assign d_rdata        = d_rdata_q;
    assign stall          = data_req & ~d_done_q;
    assign mem_addr       = mem_addr_q;
    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;
    assign mem_byteenable = mem_be_q;
    assign mem_writedata  = mem_wdata_q;
    assign err_rdv        = err_rdv_q;

endmodule
